// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes used by the ID-stage decoder and the
// execute unit, plus the execute-unit state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_OP_ADD         = 4'd0;
  localparam logic [3:0] ALU_OP_SUB         = 4'd1;
  localparam logic [3:0] ALU_OP_AND         = 4'd2;
  localparam logic [3:0] ALU_OP_OR          = 4'd3;
  localparam logic [3:0] ALU_OP_XOR         = 4'd4;
  localparam logic [3:0] ALU_OP_LT          = 4'd5;
  localparam logic [3:0] ALU_OP_NONE        = 4'd6;
  localparam logic [3:0] ALU_OP_SHIFT_LEFT  = 4'd7;
  localparam logic [3:0] ALU_OP_SHIFT_RIGHT = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_OP_SHIFT_LEFT) || (op == ALU_OP_SHIFT_RIGHT);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath: add/sub/logic/signed-compare. Pure combinational;
// the execute unit registers the result.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] and_vec;
  logic [WIDTH-1:0] or_vec;
  logic [WIDTH-1:0] xor_vec;
  logic             lt_bit;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign and_vec[gi] = op_a[gi] & op_b[gi];
      assign or_vec[gi]  = op_a[gi] | op_b[gi];
      assign xor_vec[gi] = op_a[gi] ^ op_b[gi];
    end
  endgenerate

  assign lt_bit = $signed(op_a) < $signed(op_b);

  // Shift codes and undefined codes fall to zero; shifts are handled by the parent.
  always_comb begin
    result = '0;
    case (alu_op)
      ALU_OP_ADD: result = op_a + op_b;
      ALU_OP_SUB: result = op_a - op_b;
      ALU_OP_AND: result = and_vec;
      ALU_OP_OR:  result = or_vec;
      ALU_OP_XOR: result = xor_vec;
      ALU_OP_LT:  result = {{(WIDTH-1){1'b0}}, lt_bit};
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: valid/ready input, single-cycle logic/arith ops, iterative
// one-bit-per-cycle shifts, result held until the downstream stage accepts it.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  alu_state_t           state_reg;
  logic [WIDTH-1:0]     acc_reg;
  logic [SHAMT_W-1:0]   cnt_reg;
  logic                 dir_right_reg;
  logic [WIDTH-1:0]     result_reg;
  logic                 zero_reg;
  logic                 in_ready_reg;
  logic                 out_valid_reg;
  logic [WIDTH-1:0]     core_result;

  alu_comb_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .alu_op(alu_op),
    .op_a  (op_a),
    .op_b  (op_b),
    .result(core_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      dir_right_reg <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b1;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready_reg <= 1'b0;
            if (is_shift_op(alu_op)) begin
              acc_reg       <= op_a;
              cnt_reg       <= op_b[SHAMT_W-1:0];
              dir_right_reg <= (alu_op == ALU_OP_SHIFT_RIGHT);
              state_reg     <= ST_SHIFT;
            end else begin
              result_reg    <= core_result;
              zero_reg      <= (core_result == '0);
              out_valid_reg <= 1'b1;
              state_reg     <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          // The cnt==0 edge only publishes, so shamt N costs N+1 cycles here.
          if (cnt_reg == '0) begin
            result_reg    <= acc_reg;
            zero_reg      <= (acc_reg == '0);
            out_valid_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end else begin
            acc_reg <= dir_right_reg ? (acc_reg >> 1) : (acc_reg << 1);
            cnt_reg <= cnt_reg - {{(SHAMT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign zero      = zero_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: the driver pushes expected results into
// a scoreboard queue, a negedge monitor checks latency, hold behaviour and retirement.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  alu_exec_unit #(
    .WIDTH  (32),
    .SHAMT_W(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .op_a     (op_a),
    .op_b     (op_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        zf;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   n_retired = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    int   acc_cyc;
    bit   seen;
    bit   after_retire;
    exp_t e;
    acc_cyc = 0;
    seen = 0;
    after_retire = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        seen = 0;
        after_retire = 0;
      end else begin
        if (after_retire) begin
          chk("idle_gap_out_valid", {31'b0, out_valid}, 32'd0);
          after_retire = 0;
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL spurious_output: got result %h with no pending op, expected none", result);
          end else begin
            e = exp_q[0];
            if (!seen) begin
              seen = 1;
              chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
            end
            if (out_ready) begin
              void'(exp_q.pop_front());
              chk("result", result, e.res);
              chk("zero", {31'b0, zero}, {31'b0, e.zf});
              n_retired++;
              $display("retire %0d: result=%h zero=%b (expected %h/%b, latency %0d)",
                       n_retired, result, zero, e.res, e.zf, e.lat);
              seen = 0;
              after_retire = 1;
            end else begin
              chk("hold_result", result, e.res);
              chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
            end
          end
        end
        if (in_valid && in_ready) acc_cyc = cyc;
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    op_a     = a;
    op_b     = b;
  endtask

  task automatic push_exp(input logic [31:0] r, input int lat);
    exp_t e;
    e.res = r;
    e.zf  = (r == 32'd0);
    e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic wait_accept();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        n_vec++;
        n_fail++;
        $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int lat);
    push_exp(r, lat);
    drive(op, a, b);
    wait_accept();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int c0;
    int c1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    alu_op    = 4'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    out_ready = 1'b1;

    @(negedge clk);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero", {31'b0, zero}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset in the middle of a long shift: nothing may come out.
    drive(4'd7, 32'h0000_0001, 32'd20);
    wait_accept();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_zero", {31'b0, zero}, 32'd1);
    repeat (30) @(posedge clk);
    #1;

    // Single-cycle ops.
    issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
    issue(4'd1, 32'd5,         32'd5,         32'h0000_0000, 1);
    issue(4'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1);
    issue(4'd2, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608, 1);
    issue(4'd3, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1);
    issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
    issue(4'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1);
    issue(4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
    issue(4'd5, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    issue(4'd6, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1);
    issue(4'd12, 32'hAAAA_5555, 32'h1234_5678, 32'h0000_0000, 1);
    drain();

    // Iterative shifts.
    issue(4'd7, 32'h0000_0001, 32'h0000_0025, 32'h0000_0020, 7);
    issue(4'd8, 32'h8000_0000, 32'd31,        32'h0000_0001, 33);
    issue(4'd7, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 2);
    issue(4'd8, 32'hF000_0000, 32'd4,         32'h0F00_0000, 6);
    issue(4'd8, 32'h0000_0001, 32'd1,         32'h0000_0000, 3);
    drain();

    // Backpressure: result held, second op waits until the IDLE cycle after retire.
    out_ready = 1'b0;
    issue(4'd0, 32'd3, 32'd4, 32'd7, 1);
    push_exp(32'h0000_000F, 1);
    drive(4'd3, 32'h0000_000A, 32'h0000_0005);
    repeat (10) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    drain();

    // Back-to-back stream: one accept every two cycles.
    issue(4'd0, 32'd1, 32'd2, 32'd3, 1);
    c0 = cyc;
    issue(4'd1, 32'd10, 32'd4, 32'd6, 1);
    issue(4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1);
    issue(4'd6, 32'd9, 32'd9, 32'd0, 1);
    c1 = cyc;
    chk("stream_interval", 32'(c1 - c0), 32'd6);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
